// File: rtl/tile_bram_hs.sv
// Handshaked, byte-writable tile buffer with a pipelined read path, a
// credit-guarded show-ahead response queue, optional read-during-write
// forwarding and a sequential clear engine.
module tile_bram_hs #(
    parameter int unsigned W              = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned OREG           = 1,
    parameter bit          RDW_MODE       = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned AW            = $clog2(DEPTH),
    localparam int unsigned BE_W          = W / 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_data,
    input  logic [BE_W-1:0] wr_be,
    input  logic            rd_req_valid,
    output logic            rd_req_ready,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [W-1:0]    rd_data,
    input  logic            clear,
    output logic            busy
);

    localparam int unsigned QD = OREG + 2;
    localparam int unsigned CW = $clog2(QD + 1);

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            busy_q, busy_d;
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic [CW-1:0]   cred_q, cred_d;

    logic            wr_acc, rd_acc, pop;

    logic [W-1:0]    mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [W-1:0]    mem_wd;
    logic [BE_W-1:0] mem_be;
    logic [W-1:0]    mem_rd_q;

    logic            s0_vld_q, s0_vld_d;
    logic            col_q, col_d;
    logic [W-1:0]    col_data_q, col_data_d;
    logic [BE_W-1:0] col_be_q, col_be_d;
    logic [W-1:0]    s0_word;
    logic            s1_vld_q, s1_vld_d;
    logic [W-1:0]    s1_data_q, s1_data_d;
    logic            push_vld;
    logic [W-1:0]    push_data;
    logic            push_done;

    logic [QD-1:0]   q_vld_q, q_vld_d;
    logic [W-1:0]    q_data_q [QD];
    logic [W-1:0]    q_data_d [QD];

    // Handshake qualifiers; a pop frees its credit for a request in the same cycle
    always_comb begin
        pop          = q_vld_q[0] && rd_ready;
        rd_req_ready = rd_en_q && ((cred_q < CW'(QD)) || pop);
        wr_ready     = wr_en_q;
        rd_valid     = q_vld_q[0];
        rd_data      = q_data_q[0];
        busy         = busy_q;
        wr_acc       = wr_valid && wr_en_q && rst_n;
        rd_acc       = rd_req_valid && rd_req_ready && rst_n;
    end

    // Memory write port source: clear sweep or accepted write
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wr_addr;
        mem_wd = wr_data;
        mem_be = wr_be;
        if (rst_n) begin
            if (state_q == S_CLEAR) begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                mem_be = '1;
            end else if (wr_acc) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array: byte-masked write, registered read (old data on collision)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (mem_be[i]) mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
        if (rd_acc) mem_rd_q <= mem[rd_addr];
    end

    // Control FSM next state: clear request, drain wait, sweep counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_RUN: begin
                // Pending clear blocks new requests, so zero credits means fully drained
                if (pend_q) begin
                    if (cred_q == '0) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                end else if (clear) begin
                    pend_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
        busy_d  = (state_d == S_CLEAR) || pend_d;
        wr_en_d = (state_d == S_RUN) && !pend_d;
        rd_en_d = wr_en_d;
        cred_d  = cred_q + CW'(rd_acc) - CW'(pop);
    end

    // Control state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= CLEAR_ON_RESET;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            cred_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            cred_q  <= cred_d;
        end
    end

    // Read pipeline next state: forwarding merge, optional output stage, queue shift/push
    always_comb begin
        s0_vld_d   = rd_acc;
        col_d      = rd_acc && wr_acc && (wr_addr == rd_addr);
        col_data_d = wr_data;
        col_be_d   = wr_be;
        s0_word    = mem_rd_q;
        if (RDW_MODE && col_q) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (col_be_q[i]) s0_word[8*i +: 8] = col_data_q[8*i +: 8];
            end
        end
        s1_vld_d  = s0_vld_q;
        s1_data_d = s0_word;
        push_vld  = (OREG != 0) ? s1_vld_q : s0_vld_q;
        push_data = (OREG != 0) ? s1_data_q : s0_word;

        q_vld_d  = q_vld_q;
        q_data_d = q_data_q;
        if (pop) begin
            for (int unsigned i = 0; i < QD - 1; i++) begin
                q_vld_d[i]  = q_vld_q[i+1];
                q_data_d[i] = q_data_q[i+1];
            end
            q_vld_d[QD-1] = 1'b0;
        end
        // Credits guarantee a free slot, so the pipeline never has to stall
        push_done = 1'b0;
        for (int unsigned i = 0; i < QD; i++) begin
            if (push_vld && !push_done && !q_vld_d[i]) begin
                q_vld_d[i]  = 1'b1;
                q_data_d[i] = push_data;
                push_done   = 1'b1;
            end
        end
    end

    // Read pipeline and response queue registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld_q   <= 1'b0;
            col_q      <= 1'b0;
            col_data_q <= '0;
            col_be_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            q_vld_q    <= '0;
            q_data_q   <= '{default: '0};
        end else begin
            s0_vld_q   <= s0_vld_d;
            col_q      <= col_d;
            col_data_q <= col_data_d;
            col_be_q   <= col_be_d;
            s1_vld_q   <= s1_vld_d;
            s1_data_q  <= s1_data_d;
            q_vld_q    <= q_vld_d;
            q_data_q   <= q_data_d;
        end
    end

endmodule

// File: tb/tb_tile_bram_hs.sv
// Bench for tile_bram_hs: two instances (old-data/clear-on-reset and
// forwarding/no-clear) exercised one at a time against a word-array model
// and an expected-response queue.
module tb_tile_bram_hs;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BEW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]     rst_n, wr_valid, rd_req_valid, rd_ready, clear;
    logic [1:0]     wr_ready, rd_req_ready, rd_valid, busy;
    logic [AW-1:0]  wr_addr [2];
    logic [W-1:0]   wr_data [2];
    logic [BEW-1:0] wr_be   [2];
    logic [AW-1:0]  rd_addr [2];
    logic [W-1:0]   rd_data [2];

    tile_bram_hs #(.W(32), .DEPTH(16), .OREG(1), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .wr_be(wr_be[0]),
        .rd_req_valid(rd_req_valid[0]), .rd_req_ready(rd_req_ready[0]), .rd_addr(rd_addr[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0]),
        .clear(clear[0]), .busy(busy[0])
    );

    tile_bram_hs #(.W(32), .DEPTH(16), .OREG(1), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .wr_be(wr_be[1]),
        .rd_req_valid(rd_req_valid[1]), .rd_req_ready(rd_req_ready[1]), .rd_addr(rd_addr[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1]),
        .clear(clear[1]), .busy(busy[1])
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [2][DEPTH];
    logic [31:0] expq [$];
    bit          stalled = 1'b0;
    bit          chk_rdy = 1'b0;
    logic        s_wacc, s_racc, s_pop, s_busy, s_wrdy, s_rrdy;
    logic [31:0] s_pop_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One clock: sample at negedge, check, update model, then advance
    task automatic cyc(input int d);
        logic        pop_now;
        logic [31:0] e;
        @(negedge clk);
        s_wacc  = wr_valid[d] && wr_ready[d];
        s_racc  = rd_req_valid[d] && rd_req_ready[d];
        pop_now = rd_valid[d] && rd_ready[d];
        s_pop   = pop_now;
        s_busy  = busy[d];
        s_wrdy  = wr_ready[d];
        s_rrdy  = rd_req_ready[d];
        if (expq.size() == 0) chk("no_stale_valid", {31'b0, rd_valid[d]}, 32'd0);
        else if (rd_valid[d]) begin
            if (stalled) chk("stall_hold", rd_data[d], expq[0]);
            else         chk("rd_data", rd_data[d], expq[0]);
        end
        if (chk_rdy) begin
            chk("rd_req_ready", {31'b0, rd_req_ready[d]}, {31'b0, (expq.size() < 3) || pop_now});
            chk("wr_ready_run", {31'b0, wr_ready[d]}, 32'd1);
        end
        stalled = rd_valid[d] && !rd_ready[d];
        if (pop_now) begin
            s_pop_data = rd_data[d];
            if (expq.size() > 0) e = expq.pop_front();
        end
        if (s_racc) begin
            e = model[d][rd_addr[d]];
            if (d == 1 && s_wacc && wr_addr[d] == rd_addr[d]) e = merge(e, wr_data[d], wr_be[d]);
            expq.push_back(e);
        end
        if (s_wacc) model[d][wr_addr[d]] = merge(model[d][wr_addr[d]], wr_data[d], wr_be[d]);
        @(posedge clk);
        #1;
    endtask

    task automatic rst(input int d);
        rst_n[d] = 1'b0; wr_valid[d] = 1'b0; rd_req_valid[d] = 1'b0;
        clear[d] = 1'b0; rd_ready[d] = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wr_ready",     {31'b0, wr_ready[d]},     32'd0);
        chk("rst_rd_req_ready", {31'b0, rd_req_ready[d]}, 32'd0);
        chk("rst_rd_valid",     {31'b0, rd_valid[d]},     32'd0);
        chk("rst_rd_data",      rd_data[d],               32'd0);
        chk("rst_busy",         {31'b0, busy[d]},         (d == 0) ? 32'd1 : 32'd0);
        rst_n[d] = 1'b1;
        expq.delete();
        stalled = 1'b0;
        if (d == 0) for (int a = 0; a < DEPTH; a++) model[d][a] = '0;
    endtask

    task automatic wait_sweep(input int exp_cnt);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(0);
            if (s_busy) cnt++;
            else break;
        end
        chk("sweep_busy_cycles", cnt, exp_cnt);
        chk("sweep_end_wr_ready", {31'b0, s_wrdy}, 32'd1);
        chk("sweep_end_rd_req_ready", {31'b0, s_rrdy}, 32'd1);
    endtask

    task automatic wait_ready(input int d);
        for (int k = 0; k < 20; k++) begin
            cyc(d);
            if (s_wrdy) break;
        end
        chk("ready_after_reset", {31'b0, s_wrdy}, 32'd1);
    endtask

    task automatic do_write(input int d, input logic [AW-1:0] a, input logic [31:0] v,
                            input logic [3:0] be);
        wr_valid[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v; wr_be[d] = be;
        for (int k = 0; k < 50; k++) begin
            cyc(d);
            if (s_wacc) break;
        end
        chk("wr_accept", {31'b0, s_wacc}, 32'd1);
        wr_valid[d] = 1'b0;
    endtask

    task automatic do_read(input int d, input logic [AW-1:0] a, output logic [31:0] v);
        int lat;
        rd_ready[d] = 1'b1; rd_req_valid[d] = 1'b1; rd_addr[d] = a;
        for (int k = 0; k < 50; k++) begin
            cyc(d);
            if (s_racc) break;
        end
        chk("rd_accept", {31'b0, s_racc}, 32'd1);
        rd_req_valid[d] = 1'b0;
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            cyc(d);
            lat++;
            if (s_pop) break;
        end
        chk("rd_latency", lat, 3);
        v = s_pop_data;
    endtask

    task automatic drain(input int d);
        rd_req_valid[d] = 1'b0; wr_valid[d] = 1'b0; rd_ready[d] = 1'b1;
        for (int k = 0; k < 60 && expq.size() > 0; k++) cyc(d);
        chk("drain_left", expq.size(), 0);
        repeat (3) cyc(d);
    endtask

    task automatic collide(input int d, input logic [31:0] exp);
        do_write(d, 4'd3, 32'h0, 4'hF);
        wr_valid[d] = 1'b1; wr_addr[d] = 4'd3; wr_data[d] = 32'hDEADBEEF; wr_be[d] = 4'hF;
        rd_req_valid[d] = 1'b1; rd_addr[d] = 4'd3; rd_ready[d] = 1'b1;
        cyc(d);
        chk("collide_both_accepted", {30'b0, s_wacc, s_racc}, 32'd3);
        wr_valid[d] = 1'b0; rd_req_valid[d] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(d);
            if (s_pop) break;
        end
        chk("collide_data", s_pop_data, exp);
        drain(d);
    endtask

    task automatic bp(input int d);
        int acc;
        chk_rdy = 1'b1; rd_ready[d] = 1'b0; rd_req_valid[d] = 1'b1; acc = 0;
        for (int k = 0; k < 8; k++) begin
            rd_addr[d] = AW'($urandom_range(0, DEPTH - 1));
            cyc(d);
            if (s_racc) acc++;
        end
        chk("bp_accepted", acc, 3);
        chk("bp_rd_req_ready_low", {31'b0, s_rrdy}, 32'd0);
        rd_ready[d] = 1'b1;
        cyc(d);
        chk("credit_reuse_same_cycle", {31'b0, s_racc}, 32'd1);
        chk_rdy = 1'b0;
        drain(d);
    endtask

    task automatic rnd(input int d, input int n);
        int acc;
        chk_rdy = 1'b1; acc = 0;
        for (int k = 0; k < 3000 && acc < n; k++) begin
            rd_ready[d]     = 1'($urandom_range(0, 1));
            rd_req_valid[d] = ($urandom_range(0, 3) != 0) && (acc < n);
            rd_addr[d]      = AW'($urandom_range(0, DEPTH - 1));
            wr_valid[d]     = 1'($urandom_range(0, 1));
            wr_addr[d]      = $urandom_range(0, 1) ? rd_addr[d] : AW'($urandom_range(0, DEPTH - 1));
            wr_data[d]      = $urandom;
            wr_be[d]        = BEW'($urandom_range(0, 15));
            cyc(d);
            if (s_racc) acc++;
        end
        chk("rand_reads_done", acc, n);
        chk_rdy = 1'b0;
        drain(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          cnt, acc;
        logic        overlap;
        rst_n = '0; wr_valid = '0; rd_req_valid = '0; rd_ready = '0; clear = '0;
        for (int d = 0; d < 2; d++) begin
            wr_addr[d] = '0; wr_data[d] = '0; wr_be[d] = '0; rd_addr[d] = '0;
        end

        // power-on: dut1 first so dut0's sweep is observed from its first cycle
        rst(1);
        rst(0);
        wait_sweep(16);
        wait_ready(1);

        // prefill, reset, sweep, then everything reads back zero
        for (int a = 0; a < DEPTH; a++) do_write(0, AW'(a), $urandom, 4'hF);
        for (int a = 0; a < DEPTH; a++) do_write(1, AW'(a), $urandom, 4'hF);
        rst(0);
        wait_sweep(16);
        for (int a = 0; a < DEPTH; a++) begin
            do_read(0, AW'(a), v);
            chk("post_sweep_zero", v, 32'h0);
        end

        // byte enables
        do_write(0, 4'd5, 32'h11223344, 4'hF);
        do_write(0, 4'd5, 32'hAABBCCDD, 4'b0101);
        do_read(0, 4'd5, v);
        chk("byte_enable_merge", v, 32'h11BB33DD);
        do_write(0, 4'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(0, 4'd5, v);
        chk("zero_be_noop", v, 32'h11BB33DD);

        // same-address read/write collision
        collide(0, 32'h00000000);
        collide(1, 32'hDEADBEEF);

        // backpressure and random traffic
        bp(0);
        rnd(0, 64);
        bp(1);
        rnd(1, 64);

        // clear with two reads in flight
        do_write(0, 4'd1, 32'hCAFE0001, 4'hF);
        do_write(0, 4'd2, 32'hCAFE0002, 4'hF);
        rd_ready[0] = 1'b1; rd_req_valid[0] = 1'b1;
        rd_addr[0] = 4'd1; cyc(0);
        rd_addr[0] = 4'd2; cyc(0);
        rd_req_valid[0] = 1'b0;
        clear[0] = 1'b1; cyc(0); clear[0] = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[0][a] = '0;
        cyc(0);
        chk("clear_busy_next", {31'b0, s_busy}, 32'd1);
        chk("clear_wr_ready_drop", {31'b0, s_wrdy}, 32'd0);
        cnt = 0; overlap = 1'b0;
        for (int k = 0; k < 100 && s_busy; k++) begin
            cnt++;
            overlap = overlap | s_wrdy | s_rrdy;
            cyc(0);
        end
        chk("clear_busy_covers_sweep", {31'b0, cnt >= 17}, 32'd1);
        chk("clear_no_ready_while_busy", {31'b0, overlap}, 32'd0);
        chk("clear_inflight_drained", expq.size(), 0);
        for (int a = 0; a < DEPTH; a++) begin
            do_read(0, AW'(a), v);
            chk("post_clear_zero", v, 32'h0);
        end

        // reset with three responses queued, data retained without sweep
        rd_ready[1] = 1'b0; rd_req_valid[1] = 1'b1; acc = 0;
        for (int k = 0; k < 20 && acc < 3; k++) begin
            rd_addr[1] = AW'($urandom_range(0, DEPTH - 1));
            cyc(1);
            if (s_racc) acc++;
        end
        chk("queued_before_reset", acc, 3);
        rd_req_valid[1] = 1'b0;
        repeat (3) cyc(1);
        rst(1);
        wait_ready(1);
        for (int a = 0; a < 6; a++) do_read(1, AW'($urandom_range(0, DEPTH - 1)), v);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
